// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - byte-to-serial UART transmitter, 8N1 with optional even parity
//
// Purpose:
//   Serialises bytes onto TXD. The block times its own bit periods from clk.
//   A one-entry holding register takes the next byte while a frame is in flight,
//   so back-to-back frames go out with no idle gap.
//
// Configuration:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is inserted after the
//                      data bits (11 bit periods per frame). When undefined,
//                      frames are 8N1 (10 bit periods).
//
// Ports:
//   clk       in   1  system clock, rising edge
//   RST       in   1  asynchronous, active-high reset
//   tx_data   in   8  byte to send, LSB first
//   tx_valid  in   1  tx_data valid this cycle
//   tx_ready  out  1  holding register empty; transfer on tx_valid & tx_ready
//   TXD       out  1  serial line, idles high, registered
//   tx_busy   out  1  a frame is on the line
//   tx_done   out  1  one-cycle pulse as the stop bit finishes
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 2083,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TXD,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic             r_txd;
  logic             w_txd_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_bit_end;
  logic             w_load;
  logic             w_idx_inc;
  logic             w_hs;

`ifdef UART_TX_PARITY_EN
  logic             w_parity;
  assign w_parity = ^r_shift;
`endif

  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_hs      = tx_valid & ~r_hold_full;

  assign tx_ready  = ~r_hold_full;
  assign TXD       = r_txd;
  assign tx_busy   = (r_state != S_IDLE);
  assign tx_done   = r_done;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_idx_inc   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_idx_inc = 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_done_nxt = 1'b1;
          // A waiting byte goes straight into its start bit: no idle cycle.
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath next values. TXD is computed from the *next* state so the line
  // register changes exactly on the edge that enters each bit.
  always_comb begin
    w_shift_nxt = w_load ? r_hold : r_shift;
    if (w_load) begin
      w_idx_nxt = 3'd0;
    end else if (w_idx_inc) begin
      w_idx_nxt = r_bit_idx + 3'd1;
    end else begin
      w_idx_nxt = r_bit_idx;
    end

    if (r_state == S_IDLE || w_bit_end || w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[w_idx_nxt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = w_parity;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_txd       <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
      r_done    <= w_done_nxt;
      // A handshake needs an empty register and a drain needs a full one, so
      // the two never collide on the same edge.
      if (w_hs) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

endmodule
